disp_arbiter: RTL

- Shares the 4-digit seven-segment display (the 4x8-bit digit-pattern inputs of the display multiplexer) between NREQ requesters: status, error, clock and debug sources.
- Round-robin arbitration with minimum and maximum dwell times, plus a blank gap between owners so owner changes do not smear.
- Sits directly upstream of the display multiplexer; its four digit outputs drive that multiplexer's in3..in0.

---
 rtl/disp_pkg.sv | 17 +
 rtl/rr_pick.sv | 33 +++
 rtl/disp_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display arbitration slice.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        BLANK = 2'd2
    } arb_state_e;

    localparam int unsigned DIGW   = 8;
    localparam int unsigned FRAMEW = 32;

    // Active-low segments: all off, and the middle bar only.
    localparam logic [DIGW-1:0] BLANK_PAT = 8'hFF;
    localparam logic [DIGW-1:0] DASH_PAT  = 8'hBF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr_i, cyclically.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    int unsigned cand;

    always_comb begin
        win_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = IW'(cand);
                win_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner arbitration for the 4-digit display with min/max dwell and a blank gap.
// Define DISP_ARB_PREEMPT_EN to make requester 0 urgent (preempts after minimum dwell).
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned CW        = 26,
    parameter int unsigned MIN_DWELL = 25_000_000,
    parameter int unsigned MAX_DWELL = 50_000_000,
    parameter int unsigned BLANK_CYC = 500_000,
    parameter logic [7:0]  BLANK_PAT = disp_pkg::BLANK_PAT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*FRAMEW-1:0] frame,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic [DIGW-1:0]        dig3,
    output logic [DIGW-1:0]        dig2,
    output logic [DIGW-1:0]        dig1,
    output logic [DIGW-1:0]        dig0
);

    localparam int unsigned    IW         = $clog2(NREQ);
    localparam logic [CW-1:0]  MIN_LAST   = CW'(MIN_DWELL - 1);
    localparam logic [CW-1:0]  MAX_LAST   = CW'(MAX_DWELL - 1);
    localparam logic [CW-1:0]  MAX_SAT    = CW'(MAX_DWELL);
    localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYC - 1);

    arb_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [FRAMEW-1:0]   dig_q, dig_d;

    logic [NREQ-1:0]     pick_win, sel_win;
    logic [IW-1:0]       pick_idx, sel_idx;
    logic                pick_valid, sel_valid;
    logic                others, urgent, release_own;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .win_o   (pick_win),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign others = |(req & ~gnt_q);

`ifdef DISP_ARB_PREEMPT_EN
    logic pre_q, pre_d;

    assign urgent = (owner_q != '0) && req[0];

    // After a preemptive release, requester 0 jumps the round-robin queue once.
    always_comb begin
        sel_win   = pick_win;
        sel_idx   = pick_idx;
        sel_valid = pick_valid;
        if (pre_q && req[0]) begin
            sel_win   = NREQ'(1);
            sel_idx   = '0;
            sel_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pre_q <= 1'b0;
        else        pre_q <= pre_d;
    end
`else
    assign urgent    = 1'b0;
    assign sel_win   = pick_win;
    assign sel_idx   = pick_idx;
    assign sel_valid = pick_valid;
`endif

    assign release_own = (cnt_q >= MIN_LAST) &&
                         (!req[owner_q] || ((cnt_q >= MAX_LAST) && others) || urgent);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
`ifdef DISP_ARB_PREEMPT_EN
        pre_d    = pre_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = OWN;
                    gnt_d   = sel_win;
                    owner_d = sel_idx;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (release_own) begin
                    state_d  = BLANK;
                    gnt_d    = '0;
                    cnt_d    = '0;
                    rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`ifdef DISP_ARB_PREEMPT_EN
                    pre_d    = urgent;
`endif
                end else if (cnt_q != MAX_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BLANK: begin
                if (cnt_q >= BLANK_LAST) begin
                    cnt_d = '0;
`ifdef DISP_ARB_PREEMPT_EN
                    pre_d = 1'b0;
`endif
                    if (sel_valid) begin
                        state_d = OWN;
                        gnt_d   = sel_win;
                        owner_d = sel_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Digits lag the grant by one cycle and track the owner's frame live.
    assign dig_d = (state_q == OWN) ? frame[FRAMEW*owner_q +: FRAMEW] : {4{BLANK_PAT}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            dig_q    <= {4{BLANK_PAT}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            dig_q    <= dig_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != IDLE);
    assign dig3 = dig_q[31:24];
    assign dig2 = dig_q[23:16];
    assign dig1 = dig_q[15:8];
    assign dig0 = dig_q[7:0];

endmodule
